// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM: read-first across ports, port 0 wins dual writes.
// Define DP_RAM_COLLISION_EN to add the registered same-address collision flag.
module dual_port_ram #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    din_0,
  input  logic                     cs_0,
  input  logic                     oe_0,
  input  logic                     we_0,
  input  logic [ADDRESS_WIDTH-1:0] address_0,
  output logic [DATA_WIDTH-1:0]    dout_0,
  input  logic [DATA_WIDTH-1:0]    din_1,
  input  logic                     cs_1,
  input  logic                     oe_1,
  input  logic                     we_1,
  input  logic [ADDRESS_WIDTH-1:0] address_1,
  output logic [DATA_WIDTH-1:0]    dout_1
`ifdef DP_RAM_COLLISION_EN
  ,
  output logic                     collision
`endif
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_dout_0;
  logic [DATA_WIDTH-1:0] r_dout_1;

  logic w_same_addr;
  logic w_we_0;
  logic w_we_1;
  logic w_re_0;
  logic w_re_1;

  assign w_same_addr = (address_0 == address_1);
  assign w_we_0 = cs_0 & we_0;
  // Port 1 write is dropped when port 0 writes the same word
  assign w_we_1 = cs_1 & we_1 & ~(w_we_0 & w_same_addr);
  assign w_re_0 = cs_0 & ~we_0 & oe_0;
  assign w_re_1 = cs_1 & ~we_1 & oe_1;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_we_0) r_mem[address_0] <= din_0;
      if (w_we_1) r_mem[address_1] <= din_1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout_0 <= '0;
      r_dout_1 <= '0;
    end else begin
      if (w_re_0) r_dout_0 <= r_mem[address_0];
      if (w_re_1) r_dout_1 <= r_mem[address_1];
    end
  end

  assign dout_0 = r_dout_0;
  assign dout_1 = r_dout_1;

`ifdef DP_RAM_COLLISION_EN
  logic r_collision;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_collision <= 1'b0;
    end else begin
      r_collision <= cs_0 & cs_1 & w_same_addr & (we_0 | we_1);
    end
  end

  assign collision = r_collision;
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram.
module tb_dual_port_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din_0, din_1;
  logic       cs_0, oe_0, we_0;
  logic       cs_1, oe_1, we_1;
  logic [7:0] address_0, address_1;
  logic [7:0] dout_0, dout_1;
`ifdef DP_RAM_COLLISION_EN
  logic       collision;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dual_port_ram #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_0     (din_0),
    .cs_0      (cs_0),
    .oe_0      (oe_0),
    .we_0      (we_0),
    .address_0 (address_0),
    .dout_0    (dout_0),
    .din_1     (din_1),
    .cs_1      (cs_1),
    .oe_1      (oe_1),
    .we_1      (we_1),
    .address_1 (address_1),
    .dout_1    (dout_1)
`ifdef DP_RAM_COLLISION_EN
    ,
    .collision (collision)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_col(input string tag, input logic exp);
`ifdef DP_RAM_COLLISION_EN
    chk(tag, {7'd0, collision}, {7'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  task automatic p0(input logic cs, input logic we, input logic oe,
                    input logic [7:0] a, input logic [7:0] d);
    cs_0 = cs; we_0 = we; oe_0 = oe; address_0 = a; din_0 = d;
  endtask

  task automatic p1(input logic cs, input logic we, input logic oe,
                    input logic [7:0] a, input logic [7:0] d);
    cs_1 = cs; we_1 = we; oe_1 = oe; address_1 = a; din_1 = d;
  endtask

  initial begin
    rst_n = 1'b0;
    p0(0, 0, 0, 8'd0, 8'd0);
    p1(0, 0, 0, 8'd0, 8'd0);
    tick();
    tick();
    chk("rst_dout0", dout_0, 8'h00);
    chk("rst_dout1", dout_1, 8'h00);
    chk_col("rst_col", 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      p0(1, 1, 0, 8'(i), 8'(i));
      tick();
    end
    chk("wr_no_dout", dout_0, 8'h00);

    for (int i = 0; i < 4; i++) begin
      p0(1, 0, 1, 8'(i), 8'h00);
      tick();
      chk($sformatf("rd_p0_%0d", i), dout_0, 8'(i));
    end

    p0(1, 0, 0, 8'd0, 8'h00);
    tick();
    chk("hold_oe0", dout_0, 8'h03);
    p0(0, 0, 1, 8'd1, 8'h00);
    tick();
    chk("hold_cs0", dout_0, 8'h03);
    p0(1, 1, 1, 8'd2, 8'hEE);
    tick();
    chk("hold_we0", dout_0, 8'h03);
    p0(1, 0, 1, 8'd2, 8'h00);
    tick();
    chk("wr_oe_ignored", dout_0, 8'hEE);

    p0(1, 1, 0, 8'd10, 8'hA5);
    tick();
    p0(0, 0, 0, 8'd0, 8'h00);
    p1(1, 0, 1, 8'd10, 8'h00);
    tick();
    chk("cross_rd", dout_1, 8'hA5);

    p0(1, 1, 0, 8'd20, 8'h11);
    p1(0, 0, 0, 8'd0, 8'h00);
    tick();
    p0(1, 1, 0, 8'd20, 8'h22);
    p1(1, 0, 1, 8'd20, 8'h00);
    tick();
    chk("read_first_old", dout_1, 8'h11);
    chk_col("col_rw", 1'b1);
    p0(0, 0, 0, 8'd0, 8'h00);
    tick();
    chk("read_first_new", dout_1, 8'h22);
    chk_col("col_clear", 1'b0);

    p0(1, 1, 0, 8'd30, 8'h33);
    p1(1, 1, 0, 8'd30, 8'h44);
    tick();
    chk_col("col_ww", 1'b1);
    p0(1, 0, 1, 8'd30, 8'h00);
    p1(1, 0, 1, 8'd30, 8'h00);
    tick();
    chk("dual_wr_p0", dout_0, 8'h33);
    chk("dual_rd_p1", dout_1, 8'h33);
    chk_col("col_rr", 1'b0);

    p1(0, 1'bx, 1'bx, 8'hxx, 8'hxx);
    p0(1, 1, 0, 8'd40, 8'h55);
    tick();
    chk("x_p1_dout", dout_1, 8'h33);
    p0(1, 0, 1, 8'd40, 8'h00);
    tick();
    chk("x_p1_mem40", dout_0, 8'h55);
    p0(1, 0, 1, 8'd30, 8'h00);
    tick();
    chk("x_p1_mem30", dout_0, 8'h33);
    p1(0, 0, 0, 8'd0, 8'h00);

    p0(1, 1, 0, 8'd255, 8'h9A);
    p1(1, 0, 1, 8'd0, 8'h00);
    tick();
    chk("p1_addr0", dout_1, 8'h00);
    p0(1, 0, 0, 8'd0, 8'h00);
    p1(1, 0, 1, 8'd255, 8'h00);
    tick();
    chk("top_addr", dout_1, 8'h9A);

    rst_n = 1'b0;
    p0(1, 1, 0, 8'd3, 8'h77);
    p1(1, 0, 1, 8'd255, 8'h00);
    tick();
    chk("rst_prio_d0", dout_0, 8'h00);
    chk("rst_prio_d1", dout_1, 8'h00);
    rst_n = 1'b1;
    p0(1, 0, 1, 8'd3, 8'h00);
    p1(0, 0, 0, 8'd0, 8'h00);
    tick();
    chk("rst_no_write", dout_0, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
